// File: rtl/usb_link_ctrl.sv
// -----------------------------------------------------------------------------
// usb_link_ctrl
//
// Link-level sequencer for a USB 1.x device PHY.
//   * Attach sequence on reconnect: Hi-Z (DISC), driven SE0 for CONNECT_CLKS
//     (CONN), then the pull-up on the J line is enabled and the bus released
//     (ATTACHED).
//   * Watches the received line state for bus reset (SE0 run), suspend
//     (J run) and resume (anything other than J while suspended).
//   * Arbitrates PHY transmit ownership between the handshake engine (0) and
//     the data engine (1), with an idle gap of GAP_CLKS between grants.
//
// Ports
//   rst_ni               async active-low reset
//   clk_enqueue_i        system clock
//   usb_disconnect_i     1: force detach (Hi-Z, pull-ups off)
//   line_state_i[1:0]    synchronized {dp,dm} from the PHY receiver
//   ctrl_tx_oe_o         block drives the bus (SE0 phase only)
//   ctrl_tx_dp_o         driven D+ (always 0)
//   ctrl_tx_dm_o         driven D- (always 0)
//   usb_dp_pull_up_en_o  D+ pull-up enable (full speed)
//   usb_dm_pull_up_en_o  D- pull-up enable (low speed)
//   tx_req_i[1:0]        per-source transmit request (level)
//   tx_done_i[1:0]       per-source end-of-packet pulse
//   tx_gnt_o[1:0]        one-hot transmit grant, or 0
//   bus_state_o[2:0]     0 DISC, 1 CONN, 2 ATTACHED, 3 RESET, 4 SUSPEND
//   bus_reset_o          1-cycle pulse on RESET entry
//   suspend_o            high while in SUSPEND
//   resume_o             1-cycle pulse on SUSPEND exit
//   init_ok_o            high in ATTACHED / RESET / SUSPEND
// -----------------------------------------------------------------------------
module usb_link_ctrl #(
    parameter bit USB_VER_1_X  = 1'b1,
    parameter int CONNECT_CLKS = 48,
    parameter int RESET_CLKS   = 60,
    parameter int SUSPEND_CLKS = 72000,
    parameter int GAP_CLKS     = 16
) (
    input  logic       rst_ni,
    input  logic       clk_enqueue_i,
    input  logic       usb_disconnect_i,
    input  logic [1:0] line_state_i,
    output logic       ctrl_tx_oe_o,
    output logic       ctrl_tx_dp_o,
    output logic       ctrl_tx_dm_o,
    output logic       usb_dp_pull_up_en_o,
    output logic       usb_dm_pull_up_en_o,
    input  logic [1:0] tx_req_i,
    input  logic [1:0] tx_done_i,
    output logic [1:0] tx_gnt_o,
    output logic [2:0] bus_state_o,
    output logic       bus_reset_o,
    output logic       suspend_o,
    output logic       resume_o,
    output logic       init_ok_o
);

    typedef enum logic [2:0] {
        ST_DISC     = 3'd0,
        ST_CONN     = 3'd1,
        ST_ATTACHED = 3'd2,
        ST_RESET    = 3'd3,
        ST_SUSPEND  = 3'd4
    } state_e;

    localparam int RUN_W  = 17;
    localparam int CONN_W = (CONNECT_CLKS < 2) ? 1 : $clog2(CONNECT_CLKS);
    localparam int GAP_W  = (GAP_CLKS < 2) ? 1 : $clog2(GAP_CLKS + 1);

    localparam logic [1:0]       LS_SE0    = 2'b00;
    localparam logic [1:0]       LS_J      = USB_VER_1_X ? 2'b10 : 2'b01;
    localparam logic [RUN_W-1:0] RUN_MAX   = '1;
    localparam logic [RUN_W-1:0] RUN_RESET = RUN_W'(RESET_CLKS);
    localparam logic [RUN_W-1:0] RUN_SUSP  = RUN_W'(SUSPEND_CLKS);
    localparam logic [CONN_W-1:0] CONN_LAST = CONN_W'(CONNECT_CLKS - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD  = GAP_W'(GAP_CLKS);

    state_e            state_q, state_d;
    logic [1:0]        line_q;
    logic [RUN_W-1:0]  run_cnt_q;
    logic [CONN_W-1:0] conn_cnt_q;
    logic              bus_reset_q;
    logic              resume_q;

    logic [1:0]        gnt_q;
    logic              last_q;
    logic [GAP_W-1:0]  gap_q;

    // ------------------------------------------------------------------
    // Line-state run counter: run_cnt_q is the number of consecutive
    // samples equal to line_q (the most recent sample), saturating.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_enqueue_i or negedge rst_ni) begin
        if (!rst_ni) begin
            line_q    <= 2'b00;
            run_cnt_q <= '0;
        end else begin
            line_q <= line_state_i;
            if (line_state_i != line_q) begin
                run_cnt_q <= RUN_W'(1);
            end else if (run_cnt_q != RUN_MAX) begin
                run_cnt_q <= run_cnt_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Link FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_enqueue_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_DISC;
            conn_cnt_q  <= '0;
            bus_reset_q <= 1'b0;
            resume_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            // Counts cycles spent in CONN; cleared everywhere else so each
            // reconnect sees a fresh SE0 phase.
            conn_cnt_q  <= (state_q == ST_CONN) ? conn_cnt_q + 1'b1 : '0;
            bus_reset_q <= (state_d == ST_RESET) && (state_q != ST_RESET);
            resume_q    <= (state_q == ST_SUSPEND) && (state_d == ST_ATTACHED);
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_DISC: state_d = ST_CONN;
            ST_CONN: begin
                if (conn_cnt_q == CONN_LAST) state_d = ST_ATTACHED;
            end
            ST_ATTACHED: begin
                // Thresholds act on the registered run, so the state moves
                // one edge after the run reaches its length. SE1 matches
                // neither line and just restarts the run.
                if (line_q == LS_SE0 && run_cnt_q >= RUN_RESET) begin
                    state_d = ST_RESET;
                end else if (line_q == LS_J && run_cnt_q >= RUN_SUSP) begin
                    state_d = ST_SUSPEND;
                end
            end
            ST_RESET: begin
                if (line_state_i != LS_SE0) state_d = ST_ATTACHED;
            end
            ST_SUSPEND: begin
                if (line_state_i != LS_J) state_d = ST_ATTACHED;
            end
            default: state_d = ST_DISC;
        endcase
        // Detach wins over everything; DISC then never reaches the pulse
        // conditions above.
        if (usb_disconnect_i) state_d = ST_DISC;
    end

    logic attached_like;
    assign attached_like = (state_q == ST_ATTACHED) || (state_q == ST_RESET) ||
                           (state_q == ST_SUSPEND);

    assign ctrl_tx_oe_o        = (state_q == ST_CONN);
    assign ctrl_tx_dp_o        = 1'b0;
    assign ctrl_tx_dm_o        = 1'b0;
    assign usb_dp_pull_up_en_o = attached_like && USB_VER_1_X;
    assign usb_dm_pull_up_en_o = attached_like && !USB_VER_1_X;
    assign bus_state_o         = state_q;
    assign bus_reset_o         = bus_reset_q;
    assign suspend_o           = (state_q == ST_SUSPEND);
    assign resume_o            = resume_q;
    assign init_ok_o           = attached_like;

    // ------------------------------------------------------------------
    // Transmit arbiter
    //
    // Handshake: a source holds tx_req_i high while it wants the PHY. A
    // grant appears one edge after it is issued and stays until the owner
    // pulses tx_done_i or drops its request; either ends the grant at that
    // edge and starts the idle gap. tx_done_i from a non-owner is ignored.
    // Leaving ATTACHED removes the grant at once without starting a gap.
    // ------------------------------------------------------------------
    logic       leave_att;
    logic       release_gnt;
    logic       can_issue;
    logic       pick_idx;
    logic [1:0] gnt_pick;

    assign leave_att   = (state_q == ST_ATTACHED) && (state_d != ST_ATTACHED);
    assign release_gnt = |(gnt_q & (tx_done_i | ~tx_req_i));
    // gap_q == 1 means it reaches 0 on this very edge, which is when the
    // next grant is allowed out.
    assign can_issue   = (state_q == ST_ATTACHED) && (state_d == ST_ATTACHED) &&
                         (gnt_q == 2'b00) && (gap_q <= GAP_W'(1)) &&
                         (tx_req_i != 2'b00);

    always_comb begin
        pick_idx = tx_req_i[1];
        if (tx_req_i == 2'b11) pick_idx = ~last_q;
        gnt_pick = pick_idx ? 2'b10 : 2'b01;
    end

    always_ff @(posedge clk_enqueue_i or negedge rst_ni) begin
        if (!rst_ni) begin
            gnt_q  <= 2'b00;
            last_q <= 1'b1;
            gap_q  <= '0;
        end else begin
            if (gap_q != '0) gap_q <= gap_q - 1'b1;
            if (leave_att) begin
                gnt_q <= 2'b00;
            end else if (release_gnt) begin
                gnt_q <= 2'b00;
                gap_q <= GAP_LOAD;
            end else if (can_issue) begin
                gnt_q  <= gnt_pick;
                last_q <= pick_idx;
            end
        end
    end

    assign tx_gnt_o = gnt_q;

endmodule
